// File: rtl/sm83_pkg.sv
// Shared types for the SM83 flag-update sequencer: op codes, step selector,
// FSM state and the packed strobe bundle driven into the flag register unit.
package sm83_pkg;

   localparam int FLAGS_OP_W = 4;

   typedef enum logic [FLAGS_OP_W-1:0] {
      OP_NOP    = 4'd0,
      OP_ADD    = 4'd1,
      OP_SUB    = 4'd2,
      OP_AND    = 4'd3,
      OP_LOGIC  = 4'd4,
      OP_INC    = 4'd5,
      OP_DEC    = 4'd6,
      OP_ROT    = 4'd7,
      OP_POPAF  = 4'd8,
      OP_ADD16  = 4'd9,
      OP_ADDSP  = 4'd10,
      OP_ZERO16 = 4'd11,
      OP_DAA    = 4'd12
   } flags_op_t;

   typedef enum logic {
      STEP0 = 1'b0,
      STEP1 = 1'b1
   } step_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_S0   = 2'd1,
      ST_S1   = 2'd2
   } flags_state_t;

   // Field order is MSB first; flags_bus is bit 14, sec_carry_daa is bit 0.
   typedef struct packed {
      logic flags_bus;
      logic flags_alu;
      logic zero_we;
      logic zero_clr;
      logic zero_loop;
      logic half_carry_we;
      logic half_carry_set;
      logic daa_carry_we;
      logic neg_we;
      logic neg_set;
      logic neg_clr;
      logic carry_we;
      logic sec_carry_we;
      logic sec_carry_sh;
      logic sec_carry_daa;
   } flags_strobe_t;

   function automatic logic op_two_step(input flags_op_t op);
      return op inside {OP_ADD16, OP_ADDSP, OP_ZERO16, OP_DAA};
   endfunction

endpackage

// File: rtl/sm83_alu_flags_ctl_if.sv
// Decoder-to-sequencer handshake: one flag-update op per valid/ready transfer.
interface sm83_alu_flags_ctl_if;
   import sm83_pkg::*;

   logic      op_valid;
   logic      op_ready;
   flags_op_t op;
   logic      cancel;
   logic      busy;
   logic      done;

   modport master (
      output op_valid, op, cancel,
      input  op_ready, busy, done
   );

   modport slave (
      input  op_valid, op, cancel,
      output op_ready, busy, done
   );

endinterface

// File: rtl/sm83_alu_flags_decode.sv
// Combinational map from (step, op) to the flag-unit strobe bundle.
module sm83_alu_flags_decode
   import sm83_pkg::*;
(
   input  step_t         step,
   input  flags_op_t     op,
   output flags_strobe_t strobe
);

   always_comb begin
      strobe = '0;
      case (op)
         OP_ADD, OP_SUB, OP_LOGIC: begin
            if (step == STEP0) begin
               strobe.flags_alu     = 1'b1;
               strobe.zero_we       = 1'b1;
               strobe.half_carry_we = 1'b1;
               strobe.neg_we        = 1'b1;
               strobe.neg_set       = (op == OP_SUB);
               strobe.neg_clr       = (op != OP_SUB);
               strobe.carry_we      = 1'b1;
            end
         end
         OP_AND: begin
            if (step == STEP0) begin
               strobe.flags_alu      = 1'b1;
               strobe.zero_we        = 1'b1;
               strobe.half_carry_we  = 1'b1;
               strobe.half_carry_set = 1'b1;
               strobe.neg_we         = 1'b1;
               strobe.neg_clr        = 1'b1;
               strobe.carry_we       = 1'b1;
            end
         end
         OP_INC, OP_DEC: begin
            if (step == STEP0) begin
               strobe.flags_alu     = 1'b1;
               strobe.zero_we       = 1'b1;
               strobe.half_carry_we = 1'b1;
               strobe.neg_we        = 1'b1;
               strobe.neg_set       = (op == OP_DEC);
               strobe.neg_clr       = (op == OP_INC);
            end
         end
         OP_ROT: begin
            if (step == STEP0) begin
               strobe.flags_alu     = 1'b1;
               strobe.zero_we       = 1'b1;
               strobe.half_carry_we = 1'b1;
               strobe.neg_we        = 1'b1;
               strobe.neg_clr       = 1'b1;
               strobe.sec_carry_we  = 1'b1;
               strobe.sec_carry_sh  = 1'b1;
            end
         end
         OP_POPAF: begin
            // Whole flag byte comes straight off the data bus.
            if (step == STEP0) begin
               strobe.flags_bus     = 1'b1;
               strobe.zero_we       = 1'b1;
               strobe.half_carry_we = 1'b1;
               strobe.neg_we        = 1'b1;
               strobe.carry_we      = 1'b1;
            end
         end
         OP_ADD16: begin
            strobe.flags_alu = 1'b1;
            strobe.carry_we  = 1'b1;
            if (step == STEP1) begin
               strobe.half_carry_we = 1'b1;
               strobe.neg_we        = 1'b1;
               strobe.neg_clr       = 1'b1;
            end
         end
         OP_ADDSP: begin
            strobe.flags_alu = 1'b1;
            if (step == STEP0) begin
               strobe.zero_we       = 1'b1;
               strobe.zero_clr      = 1'b1;
               strobe.half_carry_we = 1'b1;
               strobe.neg_we        = 1'b1;
               strobe.neg_clr       = 1'b1;
               strobe.carry_we      = 1'b1;
            end else begin
               strobe.sec_carry_we  = 1'b1;
            end
         end
         OP_ZERO16: begin
            strobe.flags_alu = 1'b1;
            strobe.zero_we   = 1'b1;
            strobe.zero_loop = (step == STEP1);
         end
         OP_DAA: begin
            strobe.flags_alu = 1'b1;
            if (step == STEP0) begin
               strobe.daa_carry_we  = 1'b1;
               strobe.sec_carry_we  = 1'b1;
               strobe.sec_carry_daa = 1'b1;
            end else begin
               strobe.zero_we       = 1'b1;
               strobe.half_carry_we = 1'b1;
               strobe.carry_we      = 1'b1;
            end
         end
         default: strobe = '0;
      endcase
   end

endmodule

// File: rtl/sm83_alu_flags_ctl.sv
// Flag-update sequencer: accepts one op per handshake and plays its one or
// two strobe steps into the flag register unit from registered outputs.
module sm83_alu_flags_ctl
   import sm83_pkg::*;
#(
   parameter int OP_W = FLAGS_OP_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   sm83_alu_flags_ctl_if.slave  bus,
   output logic                 flags_bus,
   output logic                 flags_alu,
   output logic                 zero_we,
   output logic                 zero_clr,
   output logic                 zero_loop,
   output logic                 half_carry_we,
   output logic                 half_carry_set,
   output logic                 daa_carry_we,
   output logic                 neg_we,
   output logic                 neg_set,
   output logic                 neg_clr,
   output logic                 carry_we,
   output logic                 sec_carry_we,
   output logic                 sec_carry_sh,
   output logic                 sec_carry_daa
);

   flags_state_t  state_reg;
   logic [OP_W-1:0] op_reg;
   flags_strobe_t strobe_reg;
   logic          done_reg;
   logic          last_reg;

   logic          busy_now;
   logic          cancel_now;
   logic          accept;
   step_t         dec_step;
   flags_op_t     dec_op;
   flags_strobe_t dec_strobe;
   flags_strobe_t strobe_out;

   assign busy_now   = (state_reg != ST_IDLE);
   assign cancel_now = busy_now && bus.cancel;
   assign bus.op_ready = (state_reg == ST_IDLE) || (last_reg && !bus.cancel);
   assign bus.busy   = busy_now;
   assign bus.done   = done_reg && !cancel_now;
   assign accept     = bus.op_valid && bus.op_ready;

   // A new op always enters at step 0; otherwise the only use of the decoder
   // is advancing the latched op to its second step.
   assign dec_step = accept ? STEP0 : STEP1;
   assign dec_op   = accept ? bus.op : flags_op_t'(op_reg);

   sm83_alu_flags_decode u_decode (
      .step   (dec_step),
      .op     (dec_op),
      .strobe (dec_strobe)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg  <= ST_IDLE;
         op_reg     <= '0;
         strobe_reg <= '0;
         done_reg   <= 1'b0;
         last_reg   <= 1'b0;
      end else if (cancel_now) begin
         state_reg  <= ST_IDLE;
         strobe_reg <= '0;
         done_reg   <= 1'b0;
         last_reg   <= 1'b0;
      end else if (accept) begin
         state_reg  <= ST_S0;
         op_reg     <= bus.op;
         strobe_reg <= dec_strobe;
         done_reg   <= !op_two_step(bus.op);
         last_reg   <= !op_two_step(bus.op);
      end else if (state_reg == ST_S0 && !last_reg) begin
         state_reg  <= ST_S1;
         strobe_reg <= dec_strobe;
         done_reg   <= 1'b1;
         last_reg   <= 1'b1;
      end else begin
         state_reg  <= ST_IDLE;
         strobe_reg <= '0;
         done_reg   <= 1'b0;
         last_reg   <= 1'b0;
      end
   end

   // Cancel has to kill the step already sitting in the output register.
   assign strobe_out = cancel_now ? '0 : strobe_reg;

   assign flags_bus      = strobe_out.flags_bus;
   assign flags_alu      = strobe_out.flags_alu;
   assign zero_we        = strobe_out.zero_we;
   assign zero_clr       = strobe_out.zero_clr;
   assign zero_loop      = strobe_out.zero_loop;
   assign half_carry_we  = strobe_out.half_carry_we;
   assign half_carry_set = strobe_out.half_carry_set;
   assign daa_carry_we   = strobe_out.daa_carry_we;
   assign neg_we         = strobe_out.neg_we;
   assign neg_set        = strobe_out.neg_set;
   assign neg_clr        = strobe_out.neg_clr;
   assign carry_we       = strobe_out.carry_we;
   assign sec_carry_we   = strobe_out.sec_carry_we;
   assign sec_carry_sh   = strobe_out.sec_carry_sh;
   assign sec_carry_daa  = strobe_out.sec_carry_daa;

endmodule

// File: doc/sm83_alu_flags_ctl.md
# sm83_alu_flags_ctl

Flag-update sequencer for the SM83 flag register unit. Accepts one flag-update operation per handshake from the CPU decoder and drives the unit's write-enable and modifier strobes for one or two cycles, covering single-byte ALU ops, bus loads (POP AF), 16-bit ops, and DAA. Sits between the decoder and the flag register unit; all strobe outputs are registered.

## Interface
Parameters:
- `OP_W`, 4, width of the op code.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  reset: asynchronous assert, active-low.
- `op_valid`  in  1  op request.
- `op_ready`  out  1  op is accepted in this cycle when `op_valid && op_ready`.
- `op`  in  `OP_W`  op code, type `flags_op_t`.
- `cancel`  in  1  synchronous abort of the op in flight.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle pulse on the last step of an op.
- Strobes, all `out 1`, with the flag unit's meaning:
  - `flags_bus`, `flags_alu`
  - `zero_we`, `zero_clr`, `zero_loop`
  - `half_carry_we`, `half_carry_set`
  - `daa_carry_we`
  - `neg_we`, `neg_set`, `neg_clr`
  - `carry_we`
  - `sec_carry_we`, `sec_carry_sh`, `sec_carry_daa`

## Operation
- FSM states: IDLE, S0, S1.
- An accepted 1-step op goes to S0, then returns to IDLE (or to S0 on a back-to-back accept).
- An accepted 2-step op goes S0 → S1 → IDLE.
- Strobes are a function of (state, latched op). In IDLE all strobes are 0.
- `flags_bus` and `flags_alu` are mutually exclusive. Exactly one is 1 whenever any `*_we` is 1; both are 0 otherwise.
- Op codes and step strobes (only the listed strobes are 1):
  - NOP=0 (S0): none.
  - ADD=1 (S0): alu, zero_we, half_carry_we, neg_we, neg_clr, carry_we.
  - SUB=2 (S0): same as ADD, with neg_set instead of neg_clr.
  - AND=3 (S0): alu, zero_we, half_carry_we, half_carry_set, neg_we, neg_clr, carry_we.
  - LOGIC=4 (S0): alu, zero_we, half_carry_we, neg_we, neg_clr, carry_we.
  - INC=5 (S0): alu, zero_we, half_carry_we, neg_we, neg_clr.
  - DEC=6 (S0): same as INC, with neg_set.
  - ROT=7 (S0): alu, zero_we, half_carry_we, neg_we, neg_clr, sec_carry_we, sec_carry_sh.
  - POPAF=8 (S0): bus, zero_we, half_carry_we, neg_we, carry_we.
  - ADD16=9:
    - S0: alu, carry_we.
    - S1: alu, half_carry_we, neg_we, neg_clr, carry_we.
  - ADDSP=10:
    - S0: alu, zero_we, zero_clr, half_carry_we, neg_we, neg_clr, carry_we.
    - S1: alu, sec_carry_we.
  - ZERO16=11:
    - S0: alu, zero_we.
    - S1: alu, zero_we, zero_loop.
  - DAA=12:
    - S0: alu, daa_carry_we, sec_carry_we, sec_carry_daa.
    - S1: alu, zero_we, half_carry_we, carry_we.
  - 13–15 are illegal. They are accepted and treated as NOP: `done` pulses, no strobes.
- Handshake:
  - `op_ready` = IDLE, or last step of the current op with `cancel` = 0.
  - `busy` = state ≠ IDLE.
- `cancel` in S0 or S1:
  - All strobes are forced to 0 in that cycle.
  - `done` = 0.
  - Next state is IDLE; `op_ready` = 0 in that cycle.
- `cancel` in IDLE is ignored.
- Reset values:
  - state IDLE.
  - All strobes 0, `busy` 0, `done` 0.
  - `op_ready` 1 once `reset_n` is high.

## Timing
- Accept in cycle N: S0 strobes appear in N+1. For a 2-step op, S1 strobes appear in N+2.
- `done` is high in the cycle of the last step.
- Back-to-back accept in the last-step cycle: the next op's S0 follows with zero bubble. Sustained throughput is 1 op/cycle for 1-step ops and 1 op per 2 cycles for 2-step ops.
- Asynchronous `reset_n` low mid-sequence: all strobes drop to 0 immediately, without waiting for a clock edge. The state returns to IDLE and the latched op is discarded.
- `op` is sampled only on accept. Changes to `op` while busy have no effect.

## Structure
- Shared package `sm83_pkg` holds:
  - `flags_op_t` enum (4 bits, values above).
  - `flags_strobe_t` packed struct of the 15 strobes.
  - `FLAGS_OP_W` = 4.
- One sub-module, `sm83_alu_flags_decode`, is combinational: (step, op) → `flags_strobe_t`. The controller registers its output.
- The FSM and handshake live in `sm83_alu_flags_ctl`.

## Test plan
- Reset: assert `reset_n`=0 mid-ADD16 S1 → all strobes 0 without a clock edge. After release, `op_ready`=1 and `busy`=0.
- ADD accepted in cycle 5 → in cycle 6: alu, zero_we, half_carry_we, neg_we, neg_clr, carry_we all 1 and `done`=1. In cycle 7, all strobes are 0.
- Back-to-back: SUB, INC, POPAF on consecutive cycles → three consecutive S0 cycles with the correct vectors. POPAF asserts `flags_bus`=1 and `flags_alu`=0. `done` is high for 3 consecutive cycles.
- ZERO16 then DAA → S0 zero_we; S1 zero_we+zero_loop; then DAA S0 daa_carry_we+sec_carry_we+sec_carry_daa; then DAA S1 zero_we+half_carry_we+carry_we. `op_ready`=0 in each S0 and 1 in each S1.
- Cancel during ADDSP S0 → no strobes and no `done` that cycle, no S1. `op_ready` returns to 1 the next cycle.
- Op 14 (illegal) → accepted, `done` pulses in N+1, no strobes. `op` changes during ADD16 S0 do not alter the S1 vector.
